// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between a UART producer and uart_tx_serializer.
// The producer holds tx_data/tx_valid until it sees tx_ready on a clock edge.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-byte holding buffer feeding a start/data/[parity]/stop FSM.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                baud_en,
    uart_tx_serializer_if.slave bus,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                tx_out
);

    if (DATA_BITS < 5 || DATA_BITS > 8 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
        $error("uart_tx_serializer: unsupported parameter combination");
    end

    localparam int                CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] buf_data;
    logic                 buf_empty;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 load;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign bus.tx_ready = buf_empty;

    // The buffer drains into the shifter from IDLE, or at the end of the last stop bit
    // so the next start bit follows with no idle gap.
    always_comb begin
        load = !buf_empty &&
               ((state == IDLE) || (state == STOP && baud_en && stop_cnt == STOP_LAST));
    end

    // NOTE: every register in this block uses <= so all branches see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data registers are reset as well so tx_out can never show X.
            state     <= IDLE;
            shift     <= '0;
            buf_data  <= '0;
            buf_empty <= 1'b1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            tx_out    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (load) begin
                        state   <= SYNC;
                        tx_busy <= 1'b1;
                    end
                end
                SYNC: begin
                    if (baud_en) begin
                        state  <= START;
                        tx_out <= 1'b0;
                    end
                end
                START: begin
                    if (baud_en) begin
                        state  <= DATA;
                        tx_out <= shift[0];
                    end
                end
                DATA: begin
                    if (baud_en) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        shift   <= shift >> 1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            tx_out <= parity_bit;
`else
                            state    <= STOP;
                            stop_cnt <= 1'b0;
                            tx_out   <= 1'b1;
`endif
                        end else begin
                            tx_out <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_en) begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        tx_out   <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_en) begin
                        if (stop_cnt == STOP_LAST) begin
                            tx_done <= 1'b1;
                            if (load) begin
                                state  <= START;
                                tx_out <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                                tx_out  <= 1'b1;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                    tx_out  <= 1'b1;
                end
            endcase

            // Drain and accept are exclusive: drain needs a full buffer, accept an empty one.
            if (load) begin
                shift     <= buf_data;
                buf_empty <= 1'b1;
                bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^buf_data) ^ 1'(PARITY_ODD);
`endif
            end else if (bus.tx_valid && buf_empty) begin
                buf_data  <= bus.tx_data;
                buf_empty <= 1'b0;
            end
        end
    end

endmodule
